pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the accumulator processor; it generalises the current PC write logic.
- It owns the PC register and evaluates the branch condition internally from the zero/negative flags.
- It adds sequential increment, unconditional jump, and a hardware return-address stack for JSR/RTS with overflow/underflow detection.
- It sits between the control unit (which supplies the request strobes) and instruction fetch (which consumes pc).

Parameters:
ADDR_W, 32, width of PC, target and stack entries
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
RESET_PC, 0, value loaded into pc on reset
INC_STEP, 1, amount added to pc on advance and used for the JSR return address

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
advance  in  1  sequential fetch step: pc <= pc + INC_STEP
branch_en  in  1  conditional branch request this cycle
branch_cond  in  3  000 BEQ, 001 BNE, 010 BMI, 011 BPL, 100 BRA (always), others never taken
zero_flag  in  1  accumulator zero flag
neg_flag  in  1  accumulator negative flag
jump  in  1  unconditional jump to target
jsr  in  1  subroutine call to target
rts  in  1  return from subroutine
target  in  ADDR_W  branch/jump/JSR destination
pc  out  ADDR_W  current program counter
taken  out  1  registered; high for one cycle after an edge on which pc was loaded from target or stack
tos  out  ADDR_W  top-of-stack entry; 0 when the stack is empty
sp  out  clog2(STACK_DEPTH)+1  number of valid stack entries
stack_full  out  1  sp == STACK_DEPTH
stack_empty  out  1  sp == 0
err_overflow  out  1  sticky; set by a JSR while full
err_underflow  out  1  sticky; set by an RTS while empty

Behaviour:
- Reset values: pc = RESET_PC; sp = 0; taken = 0; both error flags = 0; all stack entries = 0. Reset overrides every other input.
- Branch condition `cond_true`:
  - BEQ: zero_flag = 1
  - BNE: zero_flag = 0
  - BMI: neg_flag = 1
  - BPL: neg_flag = 0 and zero_flag = 0
  - BRA: 1
  - codes 101–111: 0
- Priority per edge, highest first: reset > rts > jsr > jump > (branch_en & cond_true) > advance > hold. Only the highest-priority active request acts; lower ones are dropped, not queued.
- rts with sp > 0: pc <= stack[sp-1]; sp <= sp-1; taken <= 1.
- rts with sp == 0: pc holds; err_underflow <= 1; taken <= 0.
- jsr with sp < STACK_DEPTH: stack[sp] <= pc + INC_STEP; sp <= sp+1; pc <= target; taken <= 1.
- jsr with sp == STACK_DEPTH: no push, pc holds, err_overflow <= 1, taken <= 0. The stack never wraps or overwrites an entry.
- jump: pc <= target; taken <= 1.
- Branch with branch_en and cond_true: pc <= target; taken <= 1.
- Branch with branch_en and !cond_true: falls through to advance if advance is asserted, otherwise pc holds. taken <= 0.
- advance alone: pc <= pc + INC_STEP, modulo 2^ADDR_W (wraps from all-ones to INC_STEP-1). taken <= 0.
- Latency: pc, sp, tos and the flags are visible the cycle after the request edge. tos and stack_full/empty are combinational from the registered sp and stack.
- Flags are sampled on the same edge as branch_en. The unit does not register or forward flags.
- The error flags stay set until reset.
- Reset asserted mid-sequence (e.g. during a JSR cycle) discards the request; the stack contents are cleared.

Test Plan:
- Reset, then 3 cycles of advance -> pc = 0,1,2,3; taken = 0; sp = 0; stack_empty = 1.
- pc = 0x10, branch_en, cond BEQ, zero = 1, target 0x40 -> pc = 0x40, taken = 1 for one cycle. Same with zero = 0 plus advance -> pc = 0x11, taken = 0. BPL with neg = 0, zero = 1 -> not taken.
- pc = 0x20, jsr target 0x80 -> pc = 0x80, sp = 1, tos = 0x21. Then rts -> pc = 0x21, sp = 0, taken = 1.
- Nine nested jsr with STACK_DEPTH = 8 -> after 8: stack_full = 1. 9th: pc unchanged, err_overflow = 1, sp = 8. Eight rts return the return addresses in LIFO order. The 9th rts: err_underflow = 1, pc unchanged.
- Simultaneous rts+jsr+advance with sp = 1 -> rts wins: pc = stack[0], sp = 0, no push.
- pc = 0xFFFFFFFF, advance -> pc = 0x00000000. Reset during a jsr cycle -> pc = RESET_PC, sp = 0, errors cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Function : program counter with branch evaluation, jump and a hardware
//            return-address stack (JSR/RTS) with overflow/underflow flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                 ADDR_W      = 32,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [ADDR_W-1:0]  INC_STEP    = ADDR_W'(1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           advance,
  input  logic                           branch_en,
  input  logic [2:0]                     branch_cond,
  input  logic                           zero_flag,
  input  logic                           neg_flag,
  input  logic                           jump,
  input  logic                           jsr,
  input  logic                           rts,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic                           taken,
  output logic [ADDR_W-1:0]              tos,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int                c_IDX_W = $clog2(STACK_DEPTH);
  localparam int                c_SP_W  = c_IDX_W + 1;
  localparam logic [c_SP_W-1:0] c_DEPTH = c_SP_W'(STACK_DEPTH);

  localparam logic [2:0] c_BEQ = 3'b000;
  localparam logic [2:0] c_BNE = 3'b001;
  localparam logic [2:0] c_BMI = 3'b010;
  localparam logic [2:0] c_BPL = 3'b011;
  localparam logic [2:0] c_BRA = 3'b100;

  logic [ADDR_W-1:0]  r_pc;
  logic [c_SP_W-1:0]  r_sp;
  logic               r_taken;
  logic               r_err_ov;
  logic               r_err_un;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  logic               w_cond_true;
  logic               w_full;
  logic               w_empty;
  logic [ADDR_W-1:0]  w_inc;
  logic [c_IDX_W-1:0] w_push_idx;
  logic [c_IDX_W-1:0] w_top_idx;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [c_SP_W-1:0]  w_sp_nxt;
  logic               w_taken_nxt;
  logic               w_push;
  logic               w_ov_nxt;
  logic               w_un_nxt;

  always_comb begin
    w_cond_true = 1'b0;
    case (branch_cond)
      c_BEQ:   w_cond_true = zero_flag;
      c_BNE:   w_cond_true = !zero_flag;
      c_BMI:   w_cond_true = neg_flag;
      c_BPL:   w_cond_true = !neg_flag && !zero_flag;
      c_BRA:   w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_full     = (r_sp == c_DEPTH);
  assign w_empty    = (r_sp == '0);
  assign w_inc      = r_pc + INC_STEP;
  // Low bits of sp address the next free slot; when full they wrap to 0,
  // so top-of-stack is always one below that.
  assign w_push_idx = r_sp[c_IDX_W-1:0];
  assign w_top_idx  = w_push_idx - c_IDX_W'(1);

  always_comb begin
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_taken_nxt = 1'b0;
    w_push      = 1'b0;
    w_ov_nxt    = r_err_ov;
    w_un_nxt    = r_err_un;
    if (rts) begin
      if (!w_empty) begin
        w_pc_nxt    = r_stack[w_top_idx];
        w_sp_nxt    = r_sp - c_SP_W'(1);
        w_taken_nxt = 1'b1;
      end else begin
        w_un_nxt    = 1'b1;
      end
    end else if (jsr) begin
      if (!w_full) begin
        w_push      = 1'b1;
        w_sp_nxt    = r_sp + c_SP_W'(1);
        w_pc_nxt    = target;
        w_taken_nxt = 1'b1;
      end else begin
        w_ov_nxt    = 1'b1;
      end
    end else if (jump || (branch_en && w_cond_true)) begin
      w_pc_nxt    = target;
      w_taken_nxt = 1'b1;
    end else if (advance) begin
      w_pc_nxt    = w_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_sp     <= '0;
      r_taken  <= 1'b0;
      r_err_ov <= 1'b0;
      r_err_un <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_pc     <= w_pc_nxt;
      r_sp     <= w_sp_nxt;
      r_taken  <= w_taken_nxt;
      r_err_ov <= w_ov_nxt;
      r_err_un <= w_un_nxt;
      if (w_push) begin
        r_stack[w_push_idx] <= w_inc;
      end
    end
  end

  assign pc            = r_pc;
  assign taken         = r_taken;
  assign sp            = r_sp;
  assign tos           = w_empty ? '0 : r_stack[w_top_idx];
  assign stack_full    = w_full;
  assign stack_empty   = w_empty;
  assign err_overflow  = r_err_ov;
  assign err_underflow = r_err_un;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Function : directed self-checking bench for pc_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        advance;
  logic        branch_en;
  logic [2:0]  branch_cond;
  logic        zero_flag;
  logic        neg_flag;
  logic        jump;
  logic        jsr;
  logic        rts;
  logic [31:0] target;
  logic [31:0] pc;
  logic        taken;
  logic [31:0] tos;
  logic [3:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        err_overflow;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_W(32), .STACK_DEPTH(8), .RESET_PC(32'h0), .INC_STEP(32'h1)
  ) dut (
    .clock(clock), .reset(reset), .advance(advance), .branch_en(branch_en),
    .branch_cond(branch_cond), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .jump(jump), .jsr(jsr), .rts(rts), .target(target), .pc(pc),
    .taken(taken), .tos(tos), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; advance = 0; branch_en = 0; branch_cond = 3'b000;
    zero_flag = 0; neg_flag = 0; jump = 0; jsr = 0; rts = 0; target = '0;
  endtask

  // Inputs change #1 after the rising edge, outputs are read at the same point.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] t);
    idle(); jump = 1; target = t; step(); idle();
  endtask

  logic [31:0] exp_ret [8];
  logic [31:0] cur_pc;

  initial begin
    idle();
    reset = 1;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_empty", 32'(stack_empty), 32'd1);
    chk("rst_tos", tos, 32'h0);
    chk("rst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);

    idle(); advance = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("adv_pc", pc, 32'(i));
      chk("adv_taken", 32'(taken), 32'd0);
    end
    chk("adv_sp", 32'(sp), 32'd0);

    do_jump(32'h10);
    chk("jump_pc", pc, 32'h10);
    chk("jump_taken", 32'(taken), 32'd1);

    branch_en = 1; branch_cond = 3'b000; zero_flag = 1; target = 32'h40;
    step(); idle();
    chk("beq_pc", pc, 32'h40);
    chk("beq_taken", 32'(taken), 32'd1);
    step();
    chk("hold_pc", pc, 32'h40);
    chk("taken_1cyc", 32'(taken), 32'd0);

    do_jump(32'h10);
    branch_en = 1; branch_cond = 3'b000; zero_flag = 0; advance = 1; target = 32'h40;
    step(); idle();
    chk("beq_nt_pc", pc, 32'h11);
    chk("beq_nt_taken", 32'(taken), 32'd0);

    branch_en = 1; branch_cond = 3'b011; neg_flag = 0; zero_flag = 1; target = 32'h50;
    step(); idle();
    chk("bpl_z_pc", pc, 32'h11);
    chk("bpl_z_taken", 32'(taken), 32'd0);

    branch_en = 1; branch_cond = 3'b011; neg_flag = 0; zero_flag = 0; target = 32'h50;
    step(); idle();
    chk("bpl_pc", pc, 32'h50);

    branch_en = 1; branch_cond = 3'b001; zero_flag = 1; advance = 1; target = 32'h60;
    step(); idle();
    chk("bne_nt_pc", pc, 32'h51);

    branch_en = 1; branch_cond = 3'b010; neg_flag = 1; target = 32'h60;
    step(); idle();
    chk("bmi_pc", pc, 32'h60);

    branch_en = 1; branch_cond = 3'b100; target = 32'h70;
    step(); idle();
    chk("bra_pc", pc, 32'h70);

    branch_en = 1; branch_cond = 3'b101; zero_flag = 1; neg_flag = 1; advance = 1; target = 32'h90;
    step(); idle();
    chk("code5_pc", pc, 32'h71);
    chk("code5_taken", 32'(taken), 32'd0);

    do_jump(32'h20);
    jsr = 1; target = 32'h80;
    step(); idle();
    chk("jsr_pc", pc, 32'h80);
    chk("jsr_sp", 32'(sp), 32'd1);
    chk("jsr_tos", tos, 32'h21);
    chk("jsr_taken", 32'(taken), 32'd1);
    rts = 1;
    step(); idle();
    chk("rts_pc", pc, 32'h21);
    chk("rts_sp", 32'(sp), 32'd0);
    chk("rts_taken", 32'(taken), 32'd1);
    chk("rts_empty", 32'(stack_empty), 32'd1);

    do_jump(32'h100);
    cur_pc = 32'h100;
    for (int i = 0; i < 8; i++) begin
      exp_ret[i] = cur_pc + 32'h1;
      cur_pc = 32'h200 + 32'(i) * 32'h10;
      jsr = 1; target = cur_pc;
      step(); idle();
      chk("nest_pc", pc, cur_pc);
      chk("nest_sp", 32'(sp), 32'(i + 1));
      chk("nest_tos", tos, exp_ret[i]);
    end
    chk("full", 32'(stack_full), 32'd1);
    chk("no_ov_yet", 32'(err_overflow), 32'd0);
    jsr = 1; target = 32'h999;
    step(); idle();
    chk("ov_pc", pc, 32'h270);
    chk("ov_flag", 32'(err_overflow), 32'd1);
    chk("ov_sp", 32'(sp), 32'd8);
    chk("ov_taken", 32'(taken), 32'd0);

    for (int i = 7; i >= 0; i--) begin
      rts = 1;
      step(); idle();
      chk("lifo_pc", pc, exp_ret[i]);
      chk("lifo_sp", 32'(sp), 32'(i));
    end
    chk("lifo_empty", 32'(stack_empty), 32'd1);
    chk("lifo_tos0", tos, 32'h0);
    rts = 1;
    step(); idle();
    chk("un_flag", 32'(err_underflow), 32'd1);
    chk("un_pc", pc, 32'h101);
    chk("un_taken", 32'(taken), 32'd0);
    step();
    chk("sticky_ov", 32'(err_overflow), 32'd1);
    chk("sticky_un", 32'(err_underflow), 32'd1);

    jsr = 1; target = 32'h300;
    step(); idle();
    chk("pre_sim_tos", tos, 32'h102);
    rts = 1; jsr = 1; advance = 1; target = 32'h400;
    step(); idle();
    chk("sim_pc", pc, 32'h102);
    chk("sim_sp", 32'(sp), 32'd0);
    chk("sim_taken", 32'(taken), 32'd1);

    jump = 1; advance = 1; target = 32'h33;
    step(); idle();
    chk("jump_over_adv", pc, 32'h33);

    do_jump(32'hFFFF_FFFF);
    advance = 1;
    step(); idle();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_taken", 32'(taken), 32'd0);

    jsr = 1; target = 32'h500;
    step(); idle();
    chk("pre_rst_sp", 32'(sp), 32'd1);
    reset = 1; jsr = 1; target = 32'h77;
    step(); idle();
    chk("rst_jsr_pc", pc, 32'h0);
    chk("rst_jsr_sp", 32'(sp), 32'd0);
    chk("rst_jsr_tos", tos, 32'h0);
    chk("rst_jsr_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    chk("rst_jsr_taken", 32'(taken), 32'd0);
    jsr = 1; target = 32'h600;
    step(); idle();
    chk("post_rst_tos", tos, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
